memory_stage: RTL
=================

# memory_stage

Parametrised MEM pipeline stage of the MIPS core, successor to the single-word memory stage. It sits between EX/MEM and MEM/WB and adds byte/halfword/word loads and stores with sign or zero extension. It also adds a configurable wait-state RAM with a stall handshake to upstream stages, alignment checking, and multiple memory-mapped GPIO channels with per-bit direction and synchronised inputs.

## Interface
- ADDR_SIZE, 10, RAM word-address bits (RAM depth 2**ADDR_SIZE words)
- WAIT_STATES, 1, extra cycles per RAM access (0..15)
- GPIO_CHANNELS, 2, number of 32-bit GPIO channels (1..8)
- IO_BASE, 32'hFFFF_FF00, byte base of the IO region (64-byte aligned)
- clk  in  1  clock; everything is on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- alu_data_ex_mem  in  32  byte address / ALU result
- rt_data_ex_mem  in  32  store data (right-justified)
- mem_en_ex_mem  in  1  store request
- mem_rd_ex_mem  in  1  load request
- mem_size_ex_mem  in  2  00 byte, 01 half, 10 word (11 treated as word)
- mem_signed_ex_mem  in  1  sign-extend loads
- rd_en_ex_mem, rd_addr_ex_mem[4:0], rd_data_sel_ex_mem  in  passed to WB
- stall  out  1  combinational; upstream holds EX/MEM inputs while high
- gpio  inout  32*GPIO_CHANNELS  channel c occupies bits [32c+31:32c]
- alu_data_mem_wb, mem_data_mem_wb  out  32  registered results
- rd_en_mem_wb, rd_addr_mem_wb[4:0], rd_data_sel_mem_wb  out  registered
- misalign_mem_wb  out  1  registered alignment-fault flag

## Operation
- Access: store if mem_en_ex_mem, else load if mem_rd_ex_mem. Store wins if both are set.
- Region: IO if address ≥ IO_BASE, otherwise RAM at word index addr[ADDR_SIZE+1:2].
- IO map: channel c data register at IO_BASE+8c, direction register at IO_BASE+8c+4. Bit = 1 drives that gpio bit from the data register. Bit = 0 releases it to Z.
- IO accesses are word-only; mem_size is ignored.
  - IO load of a data offset returns the synchronised gpio pins (2-flop synchroniser per bit).
  - IO load of a direction offset returns the direction register.
  - Unmapped IO offsets read 0; writes to them are ignored.
- Byte lanes are little-endian, with lane = addr[1:0].
  - Byte store writes one lane from rt[7:0].
  - Half store writes lanes {addr[1],0}+{0,1} from rt[15:0].
  - Word store writes all four lanes.
  - Other lanes are unchanged.
- Loads extract the same lanes and extend to 32 bits: sign extension if mem_signed_ex_mem, else zero extension.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]≠0, in either region.
  - Store is suppressed; load data = 0.
  - rd_en_mem_wb = 0 and misalign_mem_wb = 1 for that instruction.
  - No wait states are taken.
- FSM states:
  - IDLE → WAIT when an aligned RAM access arrives and WAIT_STATES > 0; cnt ← WAIT_STATES−1.
  - WAIT: cnt decrements each cycle. When cnt = 0 the access completes and the FSM returns to IDLE.
- stall = (IDLE ∧ aligned RAM access ∧ WAIT_STATES > 0) ∨ (WAIT ∧ cnt ≠ 0).
- Non-access instructions, IO accesses and misaligned accesses complete in IDLE with no stall.
- RAM contents are not reset; they are zero-initialised at time 0 for simulation.

## Timing
- Reset (async assert, sync release) sets:
  - all MEM/WB outputs = 0;
  - GPIO data and direction registers = 0, so all gpio bits are Z;
  - synchroniser flops = 0;
  - FSM = IDLE, cnt = 0.
- Reset during WAIT aborts the access: no RAM write, no WB update.
- The RAM write and the read/extract happen at the completing edge. A RAM access takes WAIT_STATES+1 cycles.
- MEM/WB registers load on every edge.
  - While stall = 1, a bubble is loaded: rd_en_mem_wb = 0, misalign_mem_wb = 0, other fields = current inputs.
  - On the completing edge, the real result is loaded.
- IO store updates its register on the edge after presentation. gpio pins change in the same cycle after that edge.
- gpio input-to-readable latency is 2 edges of synchronisation, plus the load's own MEM/WB edge.
- A load following a store to the same RAM address returns the new data.

## Test plan
- Reset: assert rst_n=0 mid-run → all outputs 0, gpio all Z, stall=0; after release, a load of RAM[0] returns 0.
- Byte/half/word: sw 0x8899AABB @0x10; lb @0x13 signed → 0xFFFFFF88; lbu @0x12 → 0x00000099; lh @0x10 → 0xFFFFAABB; sb 0x11 @0x11, then lw @0x10 → 0x889911BB.
- Wait states with WAIT_STATES=3: lw to RAM → stall high exactly 3 cycles, rd_en_mem_wb=0 for 3 cycles, then data and rd_en=1 on the 4th edge. With WAIT_STATES=0: no stall.
- Misalign: lw @0x12 → misalign_mem_wb=1, rd_en_mem_wb=0, no stall. sh @0x11 → RAM unchanged.
- GPIO:
  - dir ch1 = 0x0000FFFF, data = 0x1234ABCD → gpio[47:32]=0xABCD, upper 16 bits Z.
  - Drive external 0x5A5A on the Z bits → load ch1 data returns 0x5A5AABCD after synchronisation.
  - Unmapped offset IO_BASE+0x3C reads 0.
- Reset mid-WAIT: sw issued, rst_n low during stall → RAM word unchanged, FSM IDLE, stall=0.

Source files
------------

// File: rtl/memory_stage.sv
// MEM pipeline stage: byte/half/word loads and stores into a wait-state RAM,
// alignment checking, and memory-mapped GPIO channels with synchronised inputs.
//
// state  | meaning
// S_IDLE | no access in flight; non-RAM and zero-wait accesses complete here
// S_WAIT | RAM access in progress; completes when cnt_q reaches 0
module memory_stage #(
   parameter int          ADDR_SIZE     = 10,
   parameter int          WAIT_STATES   = 1,
   parameter int          GPIO_CHANNELS = 2,
   parameter logic [31:0] IO_BASE       = 32'hFFFF_FF00
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [31:0]                alu_data_ex_mem,
   input  logic [31:0]                rt_data_ex_mem,
   input  logic                       mem_en_ex_mem,
   input  logic                       mem_rd_ex_mem,
   input  logic [1:0]                 mem_size_ex_mem,
   input  logic                       mem_signed_ex_mem,
   input  logic                       rd_en_ex_mem,
   input  logic [4:0]                 rd_addr_ex_mem,
   input  logic                       rd_data_sel_ex_mem,
   output logic                       stall,
   inout  wire  [32*GPIO_CHANNELS-1:0] gpio,
   output logic [31:0]                alu_data_mem_wb,
   output logic [31:0]                mem_data_mem_wb,
   output logic                       rd_en_mem_wb,
   output logic [4:0]                 rd_addr_mem_wb,
   output logic                       rd_data_sel_mem_wb,
   output logic                       misalign_mem_wb
);

   localparam int GW       = 32 * GPIO_CHANNELS;
   localparam int DEPTH    = 2 ** ADDR_SIZE;
   localparam bit HAS_WAIT = (WAIT_STATES > 0);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   logic        is_store, is_load, is_access, is_io, is_half, is_word;
   logic        misalign, ram_acc, io_acc, complete;

   logic [31:0] ram [DEPTH];
   logic [ADDR_SIZE-1:0] widx;
   logic [1:0]  lane;
   logic [31:0] ram_rd, wdata, ld_ext, io_rd, load_data;
   logic [3:0]  be;
   logic [15:0] half_sel;
   logic [7:0]  byte_sel;

   logic [31:0] io_off;
   logic [2:0]  io_ch;
   logic        io_mapped;

   logic [GW-1:0] gpio_data_q, gpio_dir_q, sync1_q, sync2_q;

   // Access decode; IO is word-only, so its alignment is checked as a word.
   assign is_store  = mem_en_ex_mem;
   assign is_load   = !mem_en_ex_mem && mem_rd_ex_mem;
   assign is_access = is_store || is_load;
   assign is_io     = (alu_data_ex_mem >= IO_BASE);
   assign is_half   = !is_io && (mem_size_ex_mem == 2'b01);
   assign is_word   = is_io || mem_size_ex_mem[1];
   assign misalign  = is_access && ((is_half && alu_data_ex_mem[0]) ||
                                    (is_word && (alu_data_ex_mem[1:0] != 2'b00)));
   assign ram_acc   = is_access && !is_io && !misalign;
   assign io_acc    = is_access && is_io && !misalign;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (ram_acc && HAS_WAIT) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
         end
         S_WAIT: if (cnt_q == 4'd0) state_d = S_IDLE;
                 else cnt_d = cnt_q - 4'd1;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      stall = ((state_q == S_IDLE) && ram_acc && HAS_WAIT) ||
              ((state_q == S_WAIT) && (cnt_q != 4'd0));
   end

   assign complete = !stall;

   // RAM with per-lane write enables; read is combinational, captured into MEM/WB
   assign widx   = alu_data_ex_mem[ADDR_SIZE+1:2];
   assign lane   = alu_data_ex_mem[1:0];
   assign ram_rd = ram[widx];

   always_comb begin
      if (is_word) begin
         be    = 4'hF;
         wdata = rt_data_ex_mem;
      end else if (is_half) begin
         be    = lane[1] ? 4'hC : 4'h3;
         wdata = {2{rt_data_ex_mem[15:0]}};
      end else begin
         be    = 4'b0001 << lane;
         wdata = {4{rt_data_ex_mem[7:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && complete && ram_acc && is_store) begin
         for (int b = 0; b < 4; b++)
            if (be[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign half_sel = lane[1] ? ram_rd[31:16] : ram_rd[15:0];
   assign byte_sel = ram_rd[8*lane +: 8];

   always_comb begin
      if (is_word)
         ld_ext = ram_rd;
      else if (is_half)
         ld_ext = {{16{mem_signed_ex_mem & half_sel[15]}}, half_sel};
      else
         ld_ext = {{24{mem_signed_ex_mem & byte_sel[7]}}, byte_sel};
   end

   // IO map: 8 bytes per channel, data at +0 and direction at +4
   assign io_off    = alu_data_ex_mem - IO_BASE;
   assign io_ch     = io_off[5:3];
   assign io_mapped = (io_off < 32'(8 * GPIO_CHANNELS));

   always_comb begin
      io_rd = '0;
      for (int c = 0; c < GPIO_CHANNELS; c++)
         if (io_mapped && (io_ch == 3'(c)))
            io_rd = io_off[2] ? gpio_dir_q[32*c +: 32] : sync2_q[32*c +: 32];
   end

   always_comb begin
      if (misalign || !is_load) load_data = '0;
      else if (is_io)           load_data = io_rd;
      else                      load_data = ld_ext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_data_q <= '0;
         gpio_dir_q  <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
      end else begin
         sync1_q <= gpio;
         sync2_q <= sync1_q;
         if (complete && io_acc && is_store && io_mapped) begin
            for (int c = 0; c < GPIO_CHANNELS; c++)
               if (io_ch == 3'(c)) begin
                  if (io_off[2]) gpio_dir_q[32*c +: 32]  <= rt_data_ex_mem;
                  else           gpio_data_q[32*c +: 32] <= rt_data_ex_mem;
               end
         end
      end
   end

   for (genvar g = 0; g < GW; g++) begin : g_pad
      assign gpio[g] = gpio_dir_q[g] ? gpio_data_q[g] : 1'bz;
   end

   // A stalled cycle loads a bubble; the completing edge loads the real result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_data_mem_wb    <= '0;
         mem_data_mem_wb    <= '0;
         rd_en_mem_wb       <= 1'b0;
         rd_addr_mem_wb     <= '0;
         rd_data_sel_mem_wb <= 1'b0;
         misalign_mem_wb    <= 1'b0;
      end else begin
         alu_data_mem_wb    <= alu_data_ex_mem;
         rd_addr_mem_wb     <= rd_addr_ex_mem;
         rd_data_sel_mem_wb <= rd_data_sel_ex_mem;
         if (stall) begin
            mem_data_mem_wb <= '0;
            rd_en_mem_wb    <= 1'b0;
            misalign_mem_wb <= 1'b0;
         end else begin
            mem_data_mem_wb <= load_data;
            rd_en_mem_wb    <= rd_en_ex_mem && !misalign;
            misalign_mem_wb <= misalign;
         end
      end
   end

endmodule
